// File: rtl/instruction_loader.sv
// Instruction RAM owner: streams a bootstrap program into RAM, then hands the address port to the CPU PC.
// Optional LOADER_CHECKSUM_EN: the loadLast word is an XOR checksum of the load and is not written.
module instruction_loader #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_WORD   = 32'h5C000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  loadStart,
    input  logic                  loadValid,
    input  logic [31:0]           loadData,
    input  logic                  loadLast,
    output logic                  loadReady,
    input  logic [ADDR_WIDTH-1:0] fetchAddress,
    output logic [31:0]           instruction,
    output logic                  cpuStall,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic [31:0]           ramWriteData,
    output logic                  ramWriteEnable,
    input  logic [31:0]           ramReadData,
    output logic [ADDR_WIDTH:0]   loadCount,
    output logic                  loadDone,
    output logic                  loadError
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, ERROR} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          accept;
    logic          at_limit;
    logic          write_word;

    // loadStart wins over a word presented in the same cycle
    assign accept   = (state == LOAD) && loadValid && !loadStart;
    assign at_limit = (count == CW'(DEPTH - 1));

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] xor_acc;
    logic        sum_ok;

    assign sum_ok     = (loadData == xor_acc);
    assign write_word = accept && !loadLast;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            xor_acc <= '0;
        end else if (loadStart) begin
            state   <= LOAD;
            count   <= '0;
            xor_acc <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (loadValid) begin
                        if (loadLast) begin
                            state <= sum_ok ? FLUSH : ERROR;
                        end else begin
                            count   <= count + CW'(1);
                            xor_acc <= xor_acc ^ loadData;
                            if (at_limit) state <= ERROR;
                        end
                    end
                end
                FLUSH:   state <= RUN;
                default: state <= state;
            endcase
        end
    end
`else
    assign write_word = accept;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else if (loadStart) begin
            state <= LOAD;
            count <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (loadValid) begin
                        count <= count + CW'(1);
                        if (loadLast)      state <= FLUSH;
                        else if (at_limit) state <= ERROR;
                    end
                end
                FLUSH:   state <= RUN;
                default: state <= state;
            endcase
        end
    end
`endif

    // Status and RAM port decode from the state register
    assign cpuStall       = (state != RUN);
    assign loadReady      = (state == LOAD);
    assign loadDone       = (state == RUN);
    assign loadError      = (state == ERROR);
    assign loadCount      = count;
    assign instruction    = (state == RUN) ? ramReadData : NOP_WORD;
    assign ramWriteEnable = write_word;
    assign ramWriteData   = write_word ? loadData : 32'h0;
    assign ramAddress     = write_word     ? count[ADDR_WIDTH-1:0] :
                            (state == RUN) ? fetchAddress : '0;

endmodule
